// File: rtl/comb_sweep_ctrl.sv
// Built-in self-test sequencer for the 4-input block `comb`: walks all 16 input
// vectors, samples E after a settle time and checks the captured truth table.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// SETTLE | vector idx applied to A..D, waiting SETTLE_CYCLES for E to settle
// SAMPLE | E captured into truth_table[idx] and checked against expected_q
// DONE   | one-cycle done pulse; pass and outputs already final
module comb_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        E,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_table,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam state_t     STEP_STATE  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  state_t      state, state_d;
  logic [3:0]  idx, idx_d;
  logic [3:0]  cnt, cnt_d;
  logic [3:0]  vec_q, vec_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] tt_d;
  logic [4:0]  fc_d;
  logic [3:0]  ff_d;
  logic        pass_d, busy_d, done_d;

  assign {A, B, C, D} = vec_q;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    vec_d   = vec_q;
    exp_d   = exp_q;
    tt_d    = truth_table;
    fc_d    = fail_count;
    ff_d    = first_fail;
    pass_d  = pass;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          exp_d   = expected;
          idx_d   = 4'd0;
          vec_d   = 4'd0;
          cnt_d   = 4'd0;
          tt_d    = 16'd0;
          fc_d    = 5'd0;
          ff_d    = 4'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = STEP_STATE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          vec_d   = 4'd0;
          pass_d  = 1'b0;
        end else begin
          cnt_d = cnt + 4'd1;
          if (cnt == SETTLE_LAST) state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          vec_d   = 4'd0;
          pass_d  = 1'b0;
        end else begin
          tt_d[idx] = E;
          if (E != exp_q[idx]) begin
            fc_d = fail_count + 5'd1;
            if (fail_count == 5'd0) ff_d = idx;
          end
          // Final results are registered on entry to DONE so they are valid with the pulse.
          if (idx == 4'd15) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (tt_d == exp_q);
            vec_d   = 4'd0;
          end else begin
            idx_d   = idx + 4'd1;
            vec_d   = idx + 4'd1;
            cnt_d   = 4'd0;
            state_d = STEP_STATE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 4'd0;
      cnt         <= 4'd0;
      vec_q       <= 4'd0;
      exp_q       <= 16'd0;
      truth_table <= 16'd0;
      fail_count  <= 5'd0;
      first_fail  <= 4'd0;
      pass        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      cnt         <= cnt_d;
      vec_q       <= vec_d;
      exp_q       <= exp_d;
      truth_table <= tt_d;
      fail_count  <= fc_d;
      first_fail  <= ff_d;
      pass        <= pass_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Bench for comb_sweep_ctrl: two instances (settle 2 and settle 0) checked every cycle
// against a cycle-count model of the sweep, plus literal checks of known sweeps.
module tb_comb_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort;
  logic [15:0] expected, comb_tt;

  logic a0, b0, c0, d0, e0, busy0, done0, pass0;
  logic a1, b1, c1, d1, e1, busy1, done1, pass1;
  logic [15:0] tt0, tt1;
  logic [4:0]  fc0, fc1;
  logic [3:0]  ff0, ff1;

  assign e0 = comb_tt[{a0, b0, c0, d0}];
  assign e1 = comb_tt[{a1, b1, c1, d1}];

  comb_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected), .E(e0),
    .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0), .pass(pass0),
    .truth_table(tt0), .fail_count(fc0), .first_fail(ff0)
  );

  comb_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected), .E(e1),
    .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1), .pass(pass1),
    .truth_table(tt1), .fail_count(fc1), .first_fail(ff1)
  );

  logic        o_busy [2];
  logic        o_done [2];
  logic        o_pass [2];
  logic [3:0]  o_vec  [2];
  logic [15:0] o_tt   [2];
  logic [4:0]  o_fc   [2];
  logic [3:0]  o_ff   [2];
  assign o_busy[0] = busy0;  assign o_busy[1] = busy1;
  assign o_done[0] = done0;  assign o_done[1] = done1;
  assign o_pass[0] = pass0;  assign o_pass[1] = pass1;
  assign o_vec[0]  = {a0, b0, c0, d0};
  assign o_vec[1]  = {a1, b1, c1, d1};
  assign o_tt[0]   = tt0;    assign o_tt[1]   = tt1;
  assign o_fc[0]   = fc0;    assign o_fc[1]   = fc1;
  assign o_ff[0]   = ff0;    assign o_ff[1]   = ff1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", nm, k, act, req, $time);
    end
  endtask

  // Model: a running sweep is described only by the cycle number t since the
  // accepting edge; vector v occupies cycles v*(S+1)+1 .. (v+1)*(S+1), sampled in the last.
  int          settle [2] = '{2, 0};
  bit          m_run  [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  bit          m_pass [2] = '{0, 0};
  int          m_t    [2] = '{0, 0};
  logic [15:0] m_tt   [2] = '{16'd0, 16'd0};
  logic [15:0] m_exp  [2] = '{16'd0, 16'd0};
  int          m_fc   [2] = '{0, 0};
  int          m_ff   [2] = '{0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_run[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_t[k] = 0;
        m_tt[k] = 16'd0; m_exp[k] = 16'd0; m_fc[k] = 0; m_ff[k] = 0;
      end else if (m_done[k]) begin
        m_done[k] = 0;
      end else if (m_run[k]) begin
        if (abort) begin
          m_run[k]  = 0;
          m_pass[k] = 0;
        end else begin
          if (m_t[k] % (settle[k] + 1) == 0) begin
            int v;
            v = m_t[k] / (settle[k] + 1) - 1;
            m_tt[k][v] = comb_tt[v];
            if (comb_tt[v] != m_exp[k][v]) begin
              if (m_fc[k] == 0) m_ff[k] = v;
              m_fc[k]++;
            end
            if (v == 15) begin
              m_run[k]  = 0;
              m_done[k] = 1;
              m_pass[k] = (m_tt[k] == m_exp[k]);
            end
          end
          m_t[k]++;
        end
      end else if (start && !abort) begin
        m_run[k] = 1; m_t[k] = 1; m_tt[k] = 16'd0; m_fc[k] = 0; m_ff[k] = 0;
        m_pass[k] = 0; m_exp[k] = expected;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, 32'(o_busy[k]), 32'(m_run[k]));
        chk("done", k, 32'(o_done[k]), 32'(m_done[k]));
        chk("pass", k, 32'(o_pass[k]), 32'(m_pass[k]));
        chk("vector", k, 32'(o_vec[k]), m_run[k] ? 32'((m_t[k] - 1) / (settle[k] + 1)) : 32'd0);
        chk("truth_table", k, 32'(o_tt[k]), 32'(m_tt[k]));
        chk("fail_count", k, 32'(o_fc[k]), 32'(m_fc[k]));
        chk("first_fail", k, 32'(o_ff[k]), 32'(m_ff[k]));
      end
    end
  end

  // Runs one sweep on both instances; reports the cycle of each done pulse (-1 if none).
  task automatic run_sweep(input logic [15:0] tt, input logic [15:0] ex, input bit spam,
                           output int dc0, output int dc1);
    comb_tt  = tt;
    expected = ex;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc0 = -1;
    dc1 = -1;
    for (int n = 1; n <= 100; n++) begin
      if (done0 && dc0 < 0) dc0 = n;
      if (done1 && dc1 < 0) dc1 = n;
      start    = (spam && n >= 2 && n <= 14) ? 1'($urandom_range(0, 1)) : 1'b0;
      expected = 16'($urandom);
      if (dc0 >= 0 && dc1 >= 0 && n > dc0) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, 0, 32'(busy0), 0);
    chk({nm, "_done"}, 0, 32'(done0), 0);
    chk({nm, "_pass"}, 0, 32'(pass0), 0);
    chk({nm, "_vec"},  0, 32'({a0, b0, c0, d0}), 0);
    chk({nm, "_tt"},   0, 32'(tt0), 0);
    chk({nm, "_fc"},   0, 32'(fc0), 0);
    chk({nm, "_ff"},   0, 32'(ff0), 0);
  endtask

  int dc0, dc1;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = 16'd0; comb_tt = 16'd0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    chk_reset_vals("reset");

    run_sweep(16'h6996, 16'h6996, 1'b0, dc0, dc1);
    chk("xor_done_cycle", 0, dc0, 49);
    chk("xor_done_cycle", 1, dc1, 17);
    chk("xor_tt", 0, 32'(tt0), 32'h6996);
    chk("xor_pass", 0, 32'(pass0), 1);
    chk("xor_fc", 0, 32'(fc0), 0);
    chk("xor_ff", 0, 32'(ff0), 0);
    chk("xor_pass", 1, 32'(pass1), 1);
    chk("xor_tt", 1, 32'(tt1), 32'h6996);

    run_sweep(16'h6996, 16'h6997, 1'b0, dc0, dc1);
    chk("xorbad_tt", 0, 32'(tt0), 32'h6996);
    chk("xorbad_pass", 0, 32'(pass0), 0);
    chk("xorbad_fc", 0, 32'(fc0), 1);
    chk("xorbad_ff", 0, 32'(ff0), 0);

    run_sweep(16'h8000, 16'h0000, 1'b0, dc0, dc1);
    chk("and_tt", 0, 32'(tt0), 32'h8000);
    chk("and_fc", 0, 32'(fc0), 1);
    chk("and_ff", 0, 32'(ff0), 15);
    chk("and_pass", 0, 32'(pass0), 0);

    run_sweep(16'h6996, 16'h6996, 1'b1, dc0, dc1);
    chk("spam_done_cycle", 0, dc0, 49);
    chk("spam_pass", 0, 32'(pass0), 1);

    comb_tt = 16'h6996; expected = 16'h6996; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 100 && {a0, b0, c0, d0} != 4'd5; n++) @(negedge clk);
    chk("abort_reach_idx5", 0, 32'({a0, b0, c0, d0}), 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 0, 32'(busy0), 0);
    chk("abort_vec", 0, 32'({a0, b0, c0, d0}), 0);
    chk("abort_pass", 0, 32'(pass0), 0);
    chk("abort_tt_hi", 0, 32'(tt0[15:5]), 0);
    repeat (60) @(negedge clk);
    run_sweep(16'h6996, 16'h6996, 1'b0, dc0, dc1);
    chk("post_abort_pass", 0, 32'(pass0), 1);

    comb_tt = 16'h6996; expected = 16'h6996; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 100 && {a0, b0, c0, d0} != 4'd9; n++) @(negedge clk);
    chk("rst_reach_idx9", 0, 32'({a0, b0, c0, d0}), 9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("midrst");
    run_sweep(16'h6996, 16'h6996, 1'b0, dc0, dc1);
    chk("post_rst_done_cycle", 0, dc0, 49);
    chk("post_rst_pass", 0, 32'(pass0), 1);

    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 63) == 0) comb_tt = 16'($urandom);
      expected = $urandom_range(0, 1) ? comb_tt : 16'($urandom);
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 40) == 0);
      rst_n    = ($urandom_range(0, 300) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
